// File: rtl/wptr_full.sv
// Write-side pointer and full/almost-full/level tracking for the async FIFO.
// Define WPTR_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow is tied low.
module wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  wclk,
  input  logic                  w_nrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   sync_rptr,
  input  logic                  ovf_clr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] nxt_wbin;
  logic [PW-1:0] nxt_wgray;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] wlevel_nxt;
  logic          full_nxt;
  logic          almost_full_nxt;

  assign wen   = winc & ~full;
  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~sync_rptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_rptr[ADDR_WIDTH-2:0]};

  always_comb begin
    nxt_wbin  = wbin + PW'(wen);
    nxt_wgray = nxt_wbin ^ (nxt_wbin >> 1);
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(sync_rptr >> i);
    end
    wlevel_nxt      = nxt_wbin - rbin_sync;
    full_nxt        = (nxt_wgray == full_cmp);
    almost_full_nxt = (wlevel_nxt >= AFULL_LEVEL);
  end

  always_ff @(posedge wclk or negedge w_nrst) begin
    if (!w_nrst) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      wbin        <= nxt_wbin;
      wptr        <= nxt_wgray;
      full        <= full_nxt;
      almost_full <= almost_full_nxt;
      wlevel      <= wlevel_nxt;
    end
  end

`ifdef WPTR_OVERFLOW_EN
  // Set has priority over clear so a blocked write is never missed.
  always_ff @(posedge wclk or negedge w_nrst) begin
    if (!w_nrst) begin
      overflow <= 1'b0;
    end else if (winc && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed self-checking bench for wptr_full (ADDR_WIDTH=4, AFULL_THRESH=2).
// Overflow expectations follow whether WPTR_OVERFLOW_EN is defined in this build.
module tb_wptr_full;

  logic       wclk;
  logic       w_nrst;
  logic       winc;
  logic [4:0] sync_rptr;
  logic       ovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  int vectors    = 0;
  int miscompares = 0;

`ifdef WPTR_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(2)) dut (
    .wclk        (wclk),
    .w_nrst      (w_nrst),
    .winc        (winc),
    .sync_rptr   (sync_rptr),
    .ovf_clr     (ovf_clr),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic inc, input logic [4:0] rptr, input logic clr);
    winc      = inc;
    sync_rptr = rptr;
    ovf_clr   = clr;
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  logic [4:0] wb_model;

  initial begin
    w_nrst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0);
    #2 w_nrst = 1'b0;
    #1;
    checkOutput("reset_wptr",   32'(wptr),   32'h0);
    checkOutput("reset_wlevel", 32'(wlevel), 32'h0);
    checkOutput("reset_full",   32'(full),   32'h0);
    tick();
    #2 w_nrst = 1'b1;

    // Nine writes, then an asynchronous reset mid-cycle.
    applyStimulus(1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("pre_reset_wlevel", 32'(wlevel), 32'd9);
    checkOutput("pre_reset_waddr",  32'(waddr),  32'd9);
    #2 w_nrst = 1'b0;
    #1;
    checkOutput("async_rst_wlevel", 32'(wlevel),      32'd0);
    checkOutput("async_rst_wptr",   32'(wptr),        32'd0);
    checkOutput("async_rst_waddr",  32'(waddr),       32'd0);
    checkOutput("async_rst_full",   32'(full),        32'd0);
    checkOutput("async_rst_afull",  32'(almost_full), 32'd0);
    checkOutput("async_rst_ovf",    32'(overflow),    32'd0);
    checkOutput("async_rst_wen",    32'(wen),         32'd1);
    applyStimulus(1'b0, 5'd0, 1'b0);
    #1 w_nrst = 1'b1;
    tick();
    checkOutput("post_rst_waddr", 32'(waddr), 32'd0);
    checkOutput("post_rst_wptr",  32'(wptr),  32'h00);

    // Fill all 16 slots against a stationary read pointer.
    applyStimulus(1'b1, 5'b00000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput("fill_wlevel", 32'(wlevel),      32'(i));
      checkOutput("fill_afull",  32'(almost_full), 32'(i >= 14));
      checkOutput("fill_full",   32'(full),        32'(i == 16));
    end
    checkOutput("fill_wptr",  32'(wptr),  32'b11000);
    checkOutput("fill_waddr", 32'(waddr), 32'd0);

    // Writes while full are blocked and flag overflow.
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("ovf_wen", 32'(wen), 32'd0);
      tick();
      checkOutput("ovf_wptr", 32'(wptr),     32'b11000);
      checkOutput("ovf_flag", 32'(overflow), 32'(OVF_ON));
      checkOutput("ovf_full", 32'(full),     32'd1);
    end
    applyStimulus(1'b0, 5'b00000, 1'b1);
    tick();
    checkOutput("ovf_clr", 32'(overflow), 32'd0);

    // Read side frees one slot.
    applyStimulus(1'b0, 5'b00001, 1'b0);
    tick();
    checkOutput("drain_full",   32'(full),        32'd0);
    checkOutput("drain_wlevel", 32'(wlevel),      32'd15);
    checkOutput("drain_afull",  32'(almost_full), 32'd1);
    applyStimulus(1'b1, 5'b00001, 1'b0);
    tick();
    checkOutput("refill_full", 32'(full), 32'd1);
    checkOutput("refill_wptr", 32'(wptr), 32'b11001);

    // Write request and read advance land on the same edge while full.
    applyStimulus(1'b1, 5'b00011, 1'b0);
    #1;
    checkOutput("simul_wen_blocked", 32'(wen), 32'd0);
    tick();
    checkOutput("simul_full",   32'(full),   32'd0);
    checkOutput("simul_wptr",   32'(wptr),   32'b11001);
    checkOutput("simul_wlevel", 32'(wlevel), 32'd15);
    checkOutput("simul_wen",    32'(wen),    32'd1);
    tick();
    checkOutput("simul_accept_full", 32'(full), 32'd1);
    checkOutput("simul_accept_wptr", 32'(wptr), 32'b11011);

    // Empty out, then stream 40 writes with the reader one cycle behind.
    applyStimulus(1'b0, 5'b11011, 1'b0);
    tick();
    checkOutput("empty_wlevel", 32'(wlevel), 32'd0);
    wb_model = 5'd18;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, gray5(wb_model), 1'b0);
      tick();
      wb_model = wb_model + 5'd1;
      checkOutput("wrap_wptr",   32'(wptr),   32'(gray5(wb_model)));
      checkOutput("wrap_full",   32'(full),   32'd0);
      checkOutput("wrap_wlevel", 32'(wlevel <= 5'd1), 32'd1);
      if (wb_model == 5'd31) checkOutput("wrap_bin31", 32'(wptr), 32'b10000);
      if (wb_model == 5'd0)  checkOutput("wrap_zero",  32'(wptr), 32'b00000);
    end
    applyStimulus(1'b0, gray5(wb_model), 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and full-detection block for the async FIFO; write-domain counterpart of the read-pointer/empty block.
- Keeps a binary write address for the dual-port RAM and a Gray-coded write pointer for the two-flop synchronizer into the read domain.
- Compares against the read pointer already synchronized into the write domain, producing registered full, almost_full, fill level and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit); ADDR_WIDTH >= 2.
- AFULL_THRESH, 2, almost_full asserts when free entries <= AFULL_THRESH; legal range 1..DEPTH-1.

Ports:
- wclk  in  1  write-domain clock.
- w_nrst  in  1  reset; asynchronous assert, active-low.
- winc  in  1  write request from producer.
- sync_rptr  in  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wclk.
- ovf_clr  in  1  synchronous clear of overflow (used only with macro).
- wen  out  1  RAM write enable = winc & ~full (combinational).
- waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0].
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer.
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- wlevel  out  ADDR_WIDTH+1  registered occupancy as seen from the write domain, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset: w_nrst low clears wbin, wptr, full, almost_full, wlevel and overflow to 0 immediately, with no clock edge needed. Outputs waddr=0 and wen=winc.
- Registered state (all updated on posedge wclk): wbin, wptr, full, almost_full, wlevel, overflow.
- Next-state logic:
  - nxt_wbin = wbin + (winc & ~full), modulo 2**(ADDR_WIDTH+1); wraps naturally from all-ones to 0.
  - nxt_wgray = nxt_wbin ^ (nxt_wbin >> 1); wptr <= nxt_wgray. wptr must come directly from a flop (no glitches into the synchronizer).
  - full_nxt = (nxt_wgray == {~sync_rptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_rptr[ADDR_WIDTH-2:0]}).
  - rbin_sync = Gray-to-binary of sync_rptr (prefix XOR from MSB); wlevel_nxt = nxt_wbin - rbin_sync, ADDR_WIDTH+1 bits, modulo.
  - almost_full_nxt = (wlevel_nxt >= DEPTH - AFULL_THRESH).
- Latency:
  - A write accepted at edge N shows in wptr/wlevel/full after edge N.
  - A read-side advance shows up here two wclk edges after the synchronizer, then one more edge through these flops.
  - full and wlevel are therefore pessimistic: they may report full/high briefly after a read. Never optimistic.
- Writing at full: wen=0, pointers hold, RAM is not written. With the macro, overflow sets at that edge.
- Simultaneous winc and sync_rptr change while full: the write is blocked this cycle. full deasserts at the next edge if space is seen. No data is lost or duplicated.
- The last free slot is written at the same edge full asserts; the following cycle wen=0.
- Wrap: after 2*DEPTH accepted writes, wbin and wptr return to 0. The MSB inversion in the full compare gives correct full/empty across wrap.
- Invariant: wlevel never exceeds DEPTH, and full == (wlevel == DEPTH) whenever sync_rptr has been stable for 1 cycle.

Optional Feature:
- Macro: WPTR_OVERFLOW_EN.
- Defined:
  - overflow flop sets on any edge where winc & full.
  - It clears on an edge with ovf_clr=1 and no simultaneous set; set wins over clear.
  - It stays set otherwise; reset clears it.
- Undefined: overflow is tied to 0, ovf_clr is ignored, and no flop is synthesized.

Test Plan (ADDR_WIDTH=4, AFULL_THRESH=2, macro defined):
- Reset: drive w_nrst=0 mid-cycle with wlevel=9 -> all outputs 0 before the next wclk edge; after release, waddr=0, wptr=5'b00000.
- Fill: sync_rptr=5'b00000, winc=1 for 16 edges -> almost_full=1 after edge 14 (wlevel=14); full=1 and wlevel=16 after edge 16; wptr=5'b11000, waddr=0.
- Overflow: from full, winc=1 for 3 edges -> wen=0, wptr stays 5'b11000, overflow=1 after first edge; ovf_clr=1 for one edge with winc=0 -> overflow=0.
- Drain release: from full, sync_rptr -> 5'b00001 (gray 1) -> next edge full=0, wlevel=15, almost_full=1; one write -> full=1 again, wptr=5'b11001.
- Wrap: 40 writes with sync_rptr tracking wptr one cycle behind -> wptr goes 5'b10000 (bin 31) -> 5'b00000 with full never asserted; wlevel <= 1 throughout.
- Simultaneous: full, winc=1, and sync_rptr advances by 1 on the same edge -> no write that edge, full=0 next edge, write accepted the edge after.
